// File: rtl/requant_packer.sv
// Requantizes signed 32-bit activations to int8 in a 3-stage pipeline, packs four lanes per
// 32-bit word and queues the words in a first-word-fall-through FIFO toward the writer.
module requant_packer #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  input  logic        flush,
  input  logic [15:0] scale,
  input  logic [4:0]  shift,
  input  logic [7:0]  zero_point,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_count,
  output logic        overflow,
  input  logic        clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- S1: multiply ----------------
  logic               s1_valid, s1_flush;
  logic signed [48:0] s1_prod;
  logic        [4:0]  s1_shift;
  logic signed [7:0]  s1_zp;
  logic signed [48:0] mul_a, mul_b;

  assign mul_a = {{17{data_in[31]}}, data_in};
  assign mul_b = {33'd0, scale};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_flush <= flush;
      s1_prod  <= mul_a * mul_b;
      s1_shift <= shift;
      s1_zp    <= zero_point;
    end
  end

  // ---------------- S2: round, shift, offset ----------------
  // One guard bit above the product keeps the rounding add from wrapping.
  logic               s2_valid, s2_flush;
  logic signed [49:0] s2_v;
  logic signed [49:0] prod_ext, rnd, rounded, v_next;

  assign prod_ext = {s1_prod[48], s1_prod};
  assign rnd      = (s1_shift == 5'd0) ? '0 : (50'sd1 <<< (s1_shift - 5'd1));
  assign rounded  = (prod_ext + rnd) >>> s1_shift;
  assign v_next   = rounded + $signed({{42{s1_zp[7]}}, s1_zp});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_flush <= 1'b0;
      s2_v     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_flush <= s1_flush;
      s2_v     <= v_next;
    end
  end

  // ---------------- S3: saturate ----------------
  logic       s3_valid, s3_flush;
  logic [7:0] s3_byte, byte_next;

  always_comb begin
    byte_next = s2_v[7:0];
    if (s2_v > 50'sd127)       byte_next = 8'h7F;
    else if (s2_v < -50'sd128) byte_next = 8'h80;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_flush <= 1'b0;
      s3_byte  <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_flush <= s2_flush;
      s3_byte  <= byte_next;
    end
  end

  // ---------------- Packer ----------------
  // Lanes are zeroed after every push so a partial word already has its unused lanes cleared.
  logic [LANES-1:0][7:0] lanes_reg, lane_fill;
  logic [2:0]            ptr_reg, fill_count;
  logic                  push;
  logic [31:0]           push_word;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_fill[gi] = (s3_valid && ptr_reg == 3'(gi)) ? s3_byte : lanes_reg[gi];
    end
  endgenerate

  assign fill_count = ptr_reg + {2'b00, s3_valid};
  assign push       = (fill_count == 3'(LANES)) || (s3_flush && fill_count != 3'd0);
  assign push_word  = lane_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lanes_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      lanes_reg <= push ? '0 : lane_fill;
      ptr_reg   <= push ? 3'd0 : fill_count;
    end
  end

  // ---------------- Output FIFO ----------------
  logic [31:0] mem_data  [FIFO_DEPTH];
  logic [2:0]  mem_count [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        empty, full, pop, wr_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_reg[AW-1:0]]  <= push_word;
      mem_count[wr_ptr_reg[AW-1:0]] <= fill_count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (push && !wr_en)  overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 32'd0 : mem_data[rd_ptr_reg[AW-1:0]];
  assign out_count = empty ? 3'd0  : mem_count[rd_ptr_reg[AW-1:0]];

endmodule

// File: tb/tb_requant_packer.sv
// Self-checking bench for requant_packer: directed scenarios plus randomized traffic
// compared against an arithmetic reference model and an expected-word scoreboard.
module tb_requant_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        flush = 1'b0;
  logic [15:0] scale = '0;
  logic [4:0]  shift = '0;
  logic [7:0]  zero_point = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0]  pend[$];
  logic [31:0] exp_d[$];
  logic [2:0]  exp_c[$];

  requant_packer #(.LANES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .scale(scale), .shift(shift), .zero_point(zero_point), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  // Reference requantization: floor((x*scale + 2^(shift-1)) / 2^shift) + zp, then saturate.
  function automatic logic [7:0] requant(input logic [31:0] d, input logic [15:0] sc,
                                         input logic [4:0] sh, input logic [7:0] zp);
    longint p, num, den, q, v;
    p = longint'($signed(d)) * longint'(sc);
    if (sh == 0) q = p;
    else begin
      den = 64'sd1;
      for (int k = 0; k < int'(sh); k++) den = den * 2;
      num = p + den / 2;
      q = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end
    v = q + longint'($signed(zp));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic void model_accept(input bit v, input bit f, input logic [7:0] b);
    logic [31:0] w;
    if (v) pend.push_back(b);
    if (pend.size() == 4 || (f && pend.size() > 0)) begin
      w = '0;
      foreach (pend[i]) w[8*i +: 8] = pend[i];
      exp_d.push_back(w);
      exp_c.push_back(3'(pend.size()));
      pend.delete();
    end
  endfunction

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] ed;
    logic [2:0]  ec;
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got data=%h count=%0d required=no_word", out_data, out_count);
      end else begin
        ed = exp_d.pop_front();
        ec = exp_c.pop_front();
        if (out_data !== ed || out_count !== ec) begin
          bad++;
          $display("FAIL pop_word got data=%h count=%0d required data=%h count=%0d",
                   out_data, out_count, ed, ec);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit f, input logic [15:0] sc,
                       input logic [4:0] sh, input logic [7:0] zp);
    valid_in = v; data_in = d; flush = f; scale = sc; shift = sh; zero_point = zp;
    model_accept(v, f, requant(d, sc, sh, zp));
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    out_ready = 1'b1;
    idle(6);
    n = 0;
    while ((exp_d.size() != 0 || out_valid) && n < 50) begin idle(1); n++; end
    total++;
    if (exp_d.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d out_valid=%0b required pending=0 out_valid=0",
               name, exp_d.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    idle(2);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 3'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b d=%h c=%0d ovf=%0b required 0 0 0 0",
               out_valid, out_data, out_count, overflow);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 16'd1, 5'd0, 8'd0);
    idle(2);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid got=%0b required=0", out_valid);
    end
    idle(1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL basic_word got v=%0b d=%h c=%0d required v=1 d=04030201 c=4",
               out_valid, out_data, out_count);
    end
    wait_drain("basic");
  endtask

  task automatic test_saturate_flush;
    out_ready = 1'b1;
    drive(1'b1, 32'd1000, 1'b0, 16'd1, 5'd0, 8'd0);
    drive(1'b1, -32'sd1000, 1'b0, 16'd1, 5'd0, 8'd0);
    drive(1'b0, 32'd0, 1'b1, 16'd1, 5'd0, 8'd0);
    idle(3);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000807F || out_count !== 3'd2) begin
      bad++;
      $display("FAIL saturate_partial got v=%0b d=%h c=%0d required v=1 d=0000807f c=2",
               out_valid, out_data, out_count);
    end
    wait_drain("saturate");
    drive(1'b0, 32'd0, 1'b1, 16'd1, 5'd0, 8'd0);
    idle(6);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_flush got out_valid=%0b required=0", out_valid);
    end
  endtask

  task automatic test_round;
    logic [31:0] vals [4];
    vals = '{32'd3, -32'sd3, 32'd5, -32'sd5};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 16'd1, 5'd1, 8'd0);
    idle(3);
    total++;
    if (out_data !== 32'hFE03FF02 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL round_word got d=%h c=%0d required d=fe03ff02 c=4", out_data, out_count);
    end
    wait_drain("round");
  endtask

  task automatic test_zero_point;
    logic [31:0] vals [4];
    vals = '{32'd0, 32'd1, 32'd100, 32'd300};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 16'd256, 5'd8, 8'h80);
    idle(3);
    total++;
    if (out_data !== 32'h7FE48180 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL zero_point_word got d=%h c=%0d required d=7fe48180 c=4", out_data, out_count);
    end
    wait_drain("zero_point");
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) drive(1'b1, 32'(i), 1'b0, 16'd1, 5'd0, 8'd0);
    idle(5);
    void'(exp_d.pop_back());
    void'(exp_c.pop_back());
    total++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h04030201 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL overflow_hold got ovf=%0b v=%0b d=%h c=%0d required ovf=1 v=1 d=04030201 c=4",
               overflow, out_valid, out_data, out_count);
    end
    wait_drain("overflow");
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky got=%0b required=1", overflow);
    end
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got=%0b required=0", overflow);
    end
    // Drop coinciding with clear: the set must win.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b0, 16'd1, 5'd0, 8'd0);
    idle(2);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    void'(exp_d.pop_back());
    void'(exp_c.pop_back());
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set_wins got=%0b required=1", overflow);
    end
    wait_drain("set_wins");
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [15:0] sc;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
      sc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 512));
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 19) < 3, sc,
            ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10)),
            8'($urandom));
    end
    drive(1'b0, 32'd0, 1'b1, 16'd1, 5'd0, 8'd0);
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 160; i++) begin
      out_ready = ~out_ready;
      drive($urandom_range(0, 9) < 6, 32'($urandom_range(0, 4000)) - 32'd2000, 1'b0,
            16'($urandom_range(1, 300)), 5'($urandom_range(0, 9)), 8'($urandom));
    end
    drive(1'b0, 32'd0, 1'b1, 16'd1, 5'd0, 8'd0);
    wait_drain("backpressure");
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_overflow got=%0b required=0", overflow);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(50 + i), 1'b0, 16'd1, 5'd0, 8'd0);
    idle(4);
    drive(1'b1, 32'd77, 1'b0, 16'd1, 5'd0, 8'd0);
    drive(1'b1, 32'd78, 1'b0, 16'd1, 5'd0, 8'd0);
    #2 reset = 1'b1;
    #1;
    pend.delete();
    exp_d.delete();
    exp_c.delete();
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got v=%0b d=%h c=%0d required 0 0 0",
               out_valid, out_data, out_count);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) drive(1'b1, 32'(i), 1'b0, 16'd1, 5'd0, 8'd0);
    idle(3);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0C0B0A09 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL reset_mid_word got v=%0b d=%h c=%0d required v=1 d=0c0b0a09 c=4",
               out_valid, out_data, out_count);
    end
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate_flush();
    test_round();
    test_zero_point();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
